dma_dispatcher_csr: RTL and testbench
=====================================

# dma_dispatcher_csr

Host-facing dispatcher for one DMA direction: a 64-bit MMIO register block that drives the controller side of `dma_ctrl_intf` through its `disp` modport. Software programs source, destination and length. The block launches one command per length write and holds MMIO back while the command queue is full. It also exposes controller, queue, buffer and debug-counter status, and manages soft-reset and interrupt clear. One instance sits between the ASP MMIO fabric and each DMA controller (host-to-FPGA or FPGA-to-host).

## Interface
- `MMIO_ADDR_WIDTH`, 7: byte-address width of the register window.
- `SCLR_CYCLES`, 16: cycles `sclr` is held after reset release or a soft-reset request; must be ≥1.
- `DMA_DIR`, "NULL": "H2F"/"F2H"; reported in the ID register.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `mmio_address` in MMIO_ADDR_WIDTH: byte address; bits [2:0] ignored.
- `mmio_write` in 1: write request.
- `mmio_writedata` in 64: write data.
- `mmio_byteenable` in 8: byte lanes; a partial write updates only the enabled bytes.
- `mmio_read` in 1: read request.
- `mmio_readdata` out 64: read data.
- `mmio_readdatavalid` out 1: read-data qualifier.
- `mmio_waitrequest` out 1: stalls the current request.
- `ctrl` `dma_ctrl_intf.disp`: controller link.

## Operation
- Register map (byte offsets):
  - 0x00 ID: read-only constant; [63:8] = `DISP_ID`, [1:0] = direction code.
  - 0x08 STATUS: read-only; {irq, busy_wr, busy_rd, fsm state, cmdq_status}.
  - 0x10 CONTROL: write-only, self-clearing; bit0 = soft reset, bit1 = irq clear.
  - 0x18 SRC, 0x20 DST, 0x30 MAGIC_ADDR: read/write.
  - 0x28 LEN: read/write; a write launches a command.
  - 0x38 DATABUF_STATUS and 0x40 CNTRL_STS: read-only, zero-extended.
  - 0x48 CMD_ISSUED: read-only count.
  - 0x50–0x68: debug counters (see Configuration).
- Unmapped reads return 0. Unmapped writes are dropped.
- Issue FSM:
  - IDLE → WAIT_SPACE on an accepted LEN write; `cmd` latched from {SRC, DST, LEN[XFER_LENGTH_WIDTH-1:0]}.
  - WAIT_SPACE → ISSUE when `cmdq_status.full`=0; otherwise stays.
  - ISSUE: `new_cmd`=1 for exactly one cycle, CMD_ISSUED increments, → IDLE.
- Backpressure: writes to 0x18/0x20/0x28 assert `mmio_waitrequest` while the FSM is not IDLE. All other accesses never stall.
- `cmd` holds its value until the next launch.
- `host_mem_magicnumber_addr` continuously mirrors MAGIC_ADDR.
- Soft reset (CONTROL bit0):
  - `sclr` is asserted for `SCLR_CYCLES`.
  - FSM forced to IDLE; a pending command is dropped with no `new_cmd`.
  - CMD_ISSUED cleared.
  - SRC/DST/LEN/MAGIC_ADDR retained.
- IRQ clear (CONTROL bit1): `clear_irq` pulses for 1 cycle.
- Soft reset and IRQ clear in the same write: both take effect.
- Soft reset arriving in the same cycle as an ISSUE: soft reset wins and `new_cmd` is suppressed.
- CMD_ISSUED is 64-bit and wraps to 0.

## Timing
- Reset values:
  - `readdata`=0, `readdatavalid`=0, `waitrequest`=0.
  - `new_cmd`=0, `clear_irq`=0, `cmd`=0, `host_mem_magicnumber_addr`=0.
  - `sclr`=1 while `reset_n`=0, then held `SCLR_CYCLES` more cycles.
  - FSM in IDLE; all registers 0.
- Read latency: fixed 1 cycle. Exactly one `readdatavalid` per accepted read.
- Write effect: visible on the next cycle.
- Launch latency: with the queue not full, `new_cmd` asserts 2 cycles after the accepted LEN write.
- `cmdq_status.full` is sampled registered. A full flag arriving in the ISSUE cycle is ignored; the controller's queue handles overflow.
- A LEN write that is held by `waitrequest` is accepted in the first cycle `waitrequest`=0. It is never lost or duplicated.

## Configuration
- Macro: `DMA_DISPATCHER_DEBUG_COUNTERS_EN`.
- Defined: 0x50–0x68 return, in order:
  - `src_readdatavalid_counter`
  - `src_burst_cnt_counter`
  - `dst_write_counter`
  - `magic_number_counter` (zero-extended)
  
  The inputs are registered once before readback.
- Undefined: those addresses read 0, and no registers are instantiated for them.

## Structure
- `dma_pkg` holds:
  - register offset constants (`DISP_REG_*`)
  - `DISP_ID`
  - the FSM state enum `disp_fsm_e` (IDLE, WAIT_SPACE, ISSUE)
  - the CONTROL bit-position constants
- `MMIO64_DATA_WIDTH` stays in `dma_pkg`.
- Sub-module `dma_dispatcher_issue_fsm` holds the FSM, the `cmd` latch, the `new_cmd` pulse and CMD_ISSUED. The top level keeps register decode and readback.

## Test plan
- Reset: release `reset_n` → `sclr`=1 for exactly 16 cycles, then 0; ID read returns `DISP_ID`; STATUS reads 0.
- Single launch:
  - Stimulus: SRC=0x1000, DST=0x2000, LEN=0x40, queue not full.
  - Required: one `new_cmd` pulse 2 cycles after the LEN write; `cmd`={0x1000, 0x2000, 0x40}; CMD_ISSUED=1.
- Backpressure:
  - Stimulus: `full`=1 for 10 cycles, then a second SRC write attempted.
  - Required: `waitrequest` held until `full` drops; one `new_cmd` issued; second SRC write accepted 1 cycle after ISSUE.
- Soft reset mid-wait:
  - Stimulus: LEN write with `full`=1, then CONTROL=0x1.
  - Required: no `new_cmd`; FSM returns to IDLE; `sclr` high 16 cycles; SRC still reads its old value.
- IRQ and byte enables:
  - Stimulus: CONTROL=0x2; then a write to MAGIC_ADDR with byteenable=0x0F and data 0xFFFF_FFFF.
  - Required: `clear_irq` one cycle; MAGIC_ADDR upper word unchanged.
- Debug counters:
  - Stimulus: `dst_write_counter`=0x55; read 0x60.
  - Required: 0x55 with the macro defined; 0 without.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA dispatcher: register map, identity constant,
// CONTROL bit positions, issue-FSM states and the command/queue-status types.
package dma_pkg;

    localparam int MMIO64_DATA_WIDTH = 64;
    localparam int DMA_ADDR_WIDTH    = 64;
    localparam int XFER_LENGTH_WIDTH = 40;

    // Identity word reported in ID[63:8]
    localparam logic [55:0] DISP_ID = 56'hD1_5BA7_C400_0001;

    // Register byte offsets
    localparam int DISP_REG_ID             = 'h00;
    localparam int DISP_REG_STATUS         = 'h08;
    localparam int DISP_REG_CONTROL        = 'h10;
    localparam int DISP_REG_SRC            = 'h18;
    localparam int DISP_REG_DST            = 'h20;
    localparam int DISP_REG_LEN            = 'h28;
    localparam int DISP_REG_MAGIC_ADDR     = 'h30;
    localparam int DISP_REG_DATABUF_STATUS = 'h38;
    localparam int DISP_REG_CNTRL_STS      = 'h40;
    localparam int DISP_REG_CMD_ISSUED     = 'h48;
    localparam int DISP_REG_DBG_RDVALID    = 'h50;
    localparam int DISP_REG_DBG_BURST      = 'h58;
    localparam int DISP_REG_DBG_DST_WRITE  = 'h60;
    localparam int DISP_REG_DBG_MAGIC      = 'h68;

    // CONTROL register bit positions
    localparam int CTRL_SOFT_RST_BIT = 0;
    localparam int CTRL_IRQ_CLR_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        ISSUE      = 2'd2
    } disp_fsm_e;

    typedef struct packed {
        logic       full;
        logic       empty;
        logic [7:0] used_slots;
    } cmdq_status_t;

    typedef struct packed {
        logic [DMA_ADDR_WIDTH-1:0]    src_addr;
        logic [DMA_ADDR_WIDTH-1:0]    dst_addr;
        logic [XFER_LENGTH_WIDTH-1:0] xfer_length;
    } dma_cmd_t;

    // Replace only the byte lanes selected by the byte enables
    function automatic logic [63:0] be_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
        logic [63:0] r;
        r = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_ctrl_intf.sv
// Link between a dispatcher (disp modport) and its DMA controller (ctrl modport).
interface dma_ctrl_intf;
    import dma_pkg::*;

    dma_cmd_t     cmd;
    logic         new_cmd;
    logic         sclr;
    logic         clear_irq;
    logic [63:0]  host_mem_magicnumber_addr;

    cmdq_status_t cmdq_status;
    logic         busy_rd;
    logic         busy_wr;
    logic         irq;
    logic [31:0]  databuf_status;
    logic [31:0]  cntrl_sts;
    logic [63:0]  src_readdatavalid_counter;
    logic [63:0]  src_burst_cnt_counter;
    logic [63:0]  dst_write_counter;
    logic [31:0]  magic_number_counter;

    modport disp (
        output cmd, new_cmd, sclr, clear_irq, host_mem_magicnumber_addr,
        input  cmdq_status, busy_rd, busy_wr, irq, databuf_status, cntrl_sts,
               src_readdatavalid_counter, src_burst_cnt_counter,
               dst_write_counter, magic_number_counter
    );

    modport ctrl (
        input  cmd, new_cmd, sclr, clear_irq, host_mem_magicnumber_addr,
        output cmdq_status, busy_rd, busy_wr, irq, databuf_status, cntrl_sts,
               src_readdatavalid_counter, src_burst_cnt_counter,
               dst_write_counter, magic_number_counter
    );

endinterface

// File: rtl/dma_dispatcher_issue_fsm.sv
// Command issue engine: latches a command on launch, waits for queue space,
// emits a single-cycle new_cmd and counts issued commands.
module dma_dispatcher_issue_fsm
    import dma_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         soft_rst_i,
    input  logic                         launch_i,
    input  logic [DMA_ADDR_WIDTH-1:0]    src_i,
    input  logic [DMA_ADDR_WIDTH-1:0]    dst_i,
    input  logic [XFER_LENGTH_WIDTH-1:0] len_i,
    input  logic                         cmdq_full_i,
    output dma_cmd_t                     cmd_o,
    output logic                         new_cmd_o,
    output disp_fsm_e                    state_o,
    output logic [63:0]                  cmd_issued_o
);

    disp_fsm_e   state_q, state_d;
    logic        full_q;
    dma_cmd_t    cmd_q;
    logic [63:0] issued_q;

    // State register plus registered copy of the queue-full flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= cmdq_full_i;
        end
    end

    // Next-state logic; soft reset abandons any pending command
    always_comb begin
        state_d = state_q;
        if (soft_rst_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (launch_i) state_d = WAIT_SPACE;
                WAIT_SPACE: if (!full_q)  state_d = ISSUE;
                ISSUE:      state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output logic: a soft reset in the ISSUE cycle suppresses the pulse
    always_comb begin
        new_cmd_o = (state_q == ISSUE) && !soft_rst_i;
    end

    // Command latch and issued-command counter (wraps naturally at 2^64)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q    <= '0;
            issued_q <= '0;
        end else begin
            if (launch_i && state_q == IDLE) cmd_q <= '{src_i, dst_i, len_i};
            if (soft_rst_i)     issued_q <= '0;
            else if (new_cmd_o) issued_q <= issued_q + 64'd1;
        end
    end

    assign cmd_o        = cmd_q;
    assign state_o      = state_q;
    assign cmd_issued_o = issued_q;

endmodule

// File: rtl/dma_dispatcher_csr.sv
// 64-bit MMIO register block driving one DMA controller's command interface.
// Optional debug-counter readback at 0x50-0x68 is built when
// DMA_DISPATCHER_DEBUG_COUNTERS_EN is defined.
module dma_dispatcher_csr
    import dma_pkg::*;
#(
    parameter int    MMIO_ADDR_WIDTH = 7,
    parameter int    SCLR_CYCLES     = 16,
    parameter string DMA_DIR         = "NULL"
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [MMIO_ADDR_WIDTH-1:0] mmio_address,
    input  logic                       mmio_write,
    input  logic [63:0]                mmio_writedata,
    input  logic [7:0]                 mmio_byteenable,
    input  logic                       mmio_read,
    output logic [63:0]                mmio_readdata,
    output logic                       mmio_readdatavalid,
    output logic                       mmio_waitrequest,
    dma_ctrl_intf.disp                 ctrl
);

    localparam logic [1:0] DIR_CODE = (DMA_DIR == "H2F") ? 2'd1 :
                                      (DMA_DIR == "F2H") ? 2'd2 : 2'd0;
    localparam int SCLR_CNT_W = $clog2(SCLR_CYCLES + 1);

    int          reg_off;
    logic        unused_addr_lsb;
    logic        sel_src, sel_dst, sel_len, sel_magic, sel_ctrl;
    logic        fsm_busy;
    logic        wr_src, wr_dst, wr_len, wr_magic;
    logic        soft_rst, irq_clr;
    logic [63:0] src_q, src_d, dst_q, dst_d, len_q, len_d, magic_q, magic_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic        clear_irq_q;
    logic [SCLR_CNT_W-1:0] sclr_cnt_q, sclr_cnt_d;
    disp_fsm_e   fsm_state;
    dma_cmd_t    cmd;
    logic        new_cmd;
    logic [63:0] cmd_issued;

    // Word-aligned decode; the low three address bits never select anything
    assign reg_off         = int'({mmio_address[MMIO_ADDR_WIDTH-1:3], 3'b000});
    assign unused_addr_lsb = ^mmio_address[2:0];

    assign sel_src   = (reg_off == DISP_REG_SRC);
    assign sel_dst   = (reg_off == DISP_REG_DST);
    assign sel_len   = (reg_off == DISP_REG_LEN);
    assign sel_magic = (reg_off == DISP_REG_MAGIC_ADDR);
    assign sel_ctrl  = (reg_off == DISP_REG_CONTROL);

    // Only command-forming registers are held off while a launch is in flight
    assign fsm_busy         = (fsm_state != IDLE);
    assign mmio_waitrequest = mmio_write && (sel_src || sel_dst || sel_len) && fsm_busy;

    assign wr_src   = mmio_write && sel_src && !fsm_busy;
    assign wr_dst   = mmio_write && sel_dst && !fsm_busy;
    assign wr_len   = mmio_write && sel_len && !fsm_busy;
    assign wr_magic = mmio_write && sel_magic;
    assign soft_rst = mmio_write && sel_ctrl && mmio_byteenable[0] &&
                      mmio_writedata[CTRL_SOFT_RST_BIT];
    assign irq_clr  = mmio_write && sel_ctrl && mmio_byteenable[0] &&
                      mmio_writedata[CTRL_IRQ_CLR_BIT];

    // Byte-enable merge for the read/write registers
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        magic_d = magic_q;
        if (wr_src)   src_d   = be_merge(src_q,   mmio_writedata, mmio_byteenable);
        if (wr_dst)   dst_d   = be_merge(dst_q,   mmio_writedata, mmio_byteenable);
        if (wr_len)   len_d   = be_merge(len_q,   mmio_writedata, mmio_byteenable);
        if (wr_magic) magic_d = be_merge(magic_q, mmio_writedata, mmio_byteenable);
    end

    // Register storage; soft reset deliberately leaves these untouched
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            magic_q <= '0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            magic_q <= magic_d;
        end
    end

    // sclr stretch counter: reloaded by reset or soft reset, counts down to zero
    always_comb begin
        sclr_cnt_d = sclr_cnt_q;
        if (soft_rst)                sclr_cnt_d = SCLR_CNT_W'(SCLR_CYCLES);
        else if (sclr_cnt_q != '0)   sclr_cnt_d = sclr_cnt_q - SCLR_CNT_W'(1);
    end

    // sclr counter and irq-clear pulse registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclr_cnt_q  <= SCLR_CNT_W'(SCLR_CYCLES);
            clear_irq_q <= 1'b0;
        end else begin
            sclr_cnt_q  <= sclr_cnt_d;
            clear_irq_q <= irq_clr;
        end
    end

    dma_dispatcher_issue_fsm u_issue_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .soft_rst_i   (soft_rst),
        .launch_i     (wr_len),
        .src_i        (src_q),
        .dst_i        (dst_q),
        .len_i        (len_d[XFER_LENGTH_WIDTH-1:0]),
        .cmdq_full_i  (ctrl.cmdq_status.full),
        .cmd_o        (cmd),
        .new_cmd_o    (new_cmd),
        .state_o      (fsm_state),
        .cmd_issued_o (cmd_issued)
    );

`ifdef DMA_DISPATCHER_DEBUG_COUNTERS_EN
    logic [63:0] dbg_rdvalid_q, dbg_burst_q, dbg_dst_write_q;
    logic [31:0] dbg_magic_q;

    // Retime controller debug counters before they reach the read mux
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dbg_rdvalid_q   <= '0;
            dbg_burst_q     <= '0;
            dbg_dst_write_q <= '0;
            dbg_magic_q     <= '0;
        end else begin
            dbg_rdvalid_q   <= ctrl.src_readdatavalid_counter;
            dbg_burst_q     <= ctrl.src_burst_cnt_counter;
            dbg_dst_write_q <= ctrl.dst_write_counter;
            dbg_magic_q     <= ctrl.magic_number_counter;
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg = ^{ctrl.src_readdatavalid_counter, ctrl.src_burst_cnt_counter,
                          ctrl.dst_write_counter, ctrl.magic_number_counter};
`endif

    // Read mux; unmapped and write-only offsets return zero
    always_comb begin
        rdata_d = '0;
        case (reg_off)
            DISP_REG_ID:             rdata_d = {DISP_ID, 6'd0, DIR_CODE};
            DISP_REG_STATUS:         rdata_d = {49'd0, ctrl.irq, ctrl.busy_wr, ctrl.busy_rd,
                                                fsm_state, ctrl.cmdq_status};
            DISP_REG_SRC:            rdata_d = src_q;
            DISP_REG_DST:            rdata_d = dst_q;
            DISP_REG_LEN:            rdata_d = len_q;
            DISP_REG_MAGIC_ADDR:     rdata_d = magic_q;
            DISP_REG_DATABUF_STATUS: rdata_d = {32'd0, ctrl.databuf_status};
            DISP_REG_CNTRL_STS:      rdata_d = {32'd0, ctrl.cntrl_sts};
            DISP_REG_CMD_ISSUED:     rdata_d = cmd_issued;
`ifdef DMA_DISPATCHER_DEBUG_COUNTERS_EN
            DISP_REG_DBG_RDVALID:    rdata_d = dbg_rdvalid_q;
            DISP_REG_DBG_BURST:      rdata_d = dbg_burst_q;
            DISP_REG_DBG_DST_WRITE:  rdata_d = dbg_dst_write_q;
            DISP_REG_DBG_MAGIC:      rdata_d = {32'd0, dbg_magic_q};
`endif
            default:                 rdata_d = '0;
        endcase
    end

    // One-cycle read response; data holds between reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= mmio_read;
            if (mmio_read) rdata_q <= rdata_d;
        end
    end

    assign mmio_readdata      = rdata_q;
    assign mmio_readdatavalid = rvalid_q;

    assign ctrl.cmd                       = cmd;
    assign ctrl.new_cmd                   = new_cmd;
    assign ctrl.sclr                      = (sclr_cnt_q != '0) || !reset_n;
    assign ctrl.clear_irq                 = clear_irq_q;
    assign ctrl.host_mem_magicnumber_addr = magic_q;

endmodule

// File: tb/tb_dma_dispatcher_csr.sv
// Directed bench for dma_dispatcher_csr (H2F instance, 16-cycle sclr).
module tb_dma_dispatcher_csr;
    import dma_pkg::*;

    localparam logic [6:0] A_ID     = 7'h00;
    localparam logic [6:0] A_STATUS = 7'h08;
    localparam logic [6:0] A_CTRL   = 7'h10;
    localparam logic [6:0] A_SRC    = 7'h18;
    localparam logic [6:0] A_DST    = 7'h20;
    localparam logic [6:0] A_LEN    = 7'h28;
    localparam logic [6:0] A_MAGIC  = 7'h30;
    localparam logic [6:0] A_ISSUED = 7'h48;
    localparam logic [6:0] A_DBG_DW = 7'h60;
    localparam logic [6:0] A_UNMAP0 = 7'h70;
    localparam logic [6:0] A_UNMAP1 = 7'h78;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  mmio_address;
    logic        mmio_write;
    logic [63:0] mmio_writedata;
    logic [7:0]  mmio_byteenable;
    logic        mmio_read;
    logic [63:0] mmio_readdata;
    logic        mmio_readdatavalid;
    logic        mmio_waitrequest;

    dma_ctrl_intf ctrl_if ();

    dma_dispatcher_csr #(
        .MMIO_ADDR_WIDTH (7),
        .SCLR_CYCLES     (16),
        .DMA_DIR         ("H2F")
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mmio_address       (mmio_address),
        .mmio_write         (mmio_write),
        .mmio_writedata     (mmio_writedata),
        .mmio_byteenable    (mmio_byteenable),
        .mmio_read          (mmio_read),
        .mmio_readdata      (mmio_readdata),
        .mmio_readdatavalid (mmio_readdatavalid),
        .mmio_waitrequest   (mmio_waitrequest),
        .ctrl               (ctrl_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int newcmd_cnt = 0;

    always @(posedge clk) begin
        if (ctrl_if.new_cmd === 1'b1) newcmd_cnt <= newcmd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; write is accepted on the first edge without waitrequest
    task automatic mmio_wr(input logic [6:0] a, input logic [63:0] d, input logic [7:0] be);
        int n = 0;
        mmio_address = a; mmio_writedata = d; mmio_byteenable = be; mmio_write = 1'b1;
        while (mmio_waitrequest && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wr_timeout", 64'(n), 64'd0);
        @(posedge clk);
        @(negedge clk);
        mmio_write = 1'b0;
    endtask

    task automatic mmio_rd(input logic [6:0] a, output logic [63:0] d);
        mmio_address = a; mmio_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mmio_read = 1'b0;
        check($sformatf("rvalid@%0h", a), 64'(mmio_readdatavalid), 64'd1);
        d = mmio_readdata;
    endtask

    task automatic count_sclr(output int hi);
        hi = 0;
        repeat (20) begin
            if (ctrl_if.sclr === 1'b1) hi++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int hi, base, n, ok;

        reset_n = 1'b0;
        mmio_address = '0; mmio_write = 1'b0; mmio_writedata = '0;
        mmio_byteenable = '0; mmio_read = 1'b0;
        ctrl_if.cmdq_status = '0; ctrl_if.busy_rd = 1'b0; ctrl_if.busy_wr = 1'b0;
        ctrl_if.irq = 1'b0; ctrl_if.databuf_status = '0; ctrl_if.cntrl_sts = '0;
        ctrl_if.src_readdatavalid_counter = '0; ctrl_if.src_burst_cnt_counter = '0;
        ctrl_if.dst_write_counter = '0; ctrl_if.magic_number_counter = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sclr",      64'(ctrl_if.sclr), 64'd1);
        check("rst_rdata",     mmio_readdata, 64'd0);
        check("rst_rvalid",    64'(mmio_readdatavalid), 64'd0);
        check("rst_waitreq",   64'(mmio_waitrequest), 64'd0);
        check("rst_new_cmd",   64'(ctrl_if.new_cmd), 64'd0);
        check("rst_clear_irq", 64'(ctrl_if.clear_irq), 64'd0);
        check("rst_cmd_src",   ctrl_if.cmd.src_addr, 64'd0);
        check("rst_magic",     ctrl_if.host_mem_magicnumber_addr, 64'd0);
        reset_n = 1'b1;
        count_sclr(hi);
        check("sclr_after_reset", 64'(hi), 64'd16);
        check("sclr_low", 64'(ctrl_if.sclr), 64'd0);
        mmio_rd(A_ID, d);     check("id", d, 64'hD15BA7C4000001_01);
        mmio_rd(A_STATUS, d); check("status_reset", d, 64'd0);
        mmio_rd(A_SRC, d);    check("src_reset", d, 64'd0);

        // Single launch
        mmio_wr(A_SRC, 64'h1000, 8'hFF);
        mmio_wr(A_DST, 64'h2000, 8'hFF);
        base = newcmd_cnt;
        mmio_wr(A_LEN, 64'h40, 8'hFF);
        check("launch_cyc1", 64'(ctrl_if.new_cmd), 64'd0);
        @(negedge clk);
        check("launch_cyc2",  64'(ctrl_if.new_cmd), 64'd1);
        check("launch_src",   ctrl_if.cmd.src_addr, 64'h1000);
        check("launch_dst",   ctrl_if.cmd.dst_addr, 64'h2000);
        check("launch_len",   64'(ctrl_if.cmd.xfer_length), 64'h40);
        @(negedge clk);
        check("launch_cyc3",  64'(ctrl_if.new_cmd), 64'd0);
        check("launch_count", 64'(newcmd_cnt - base), 64'd1);
        mmio_rd(A_ISSUED, d); check("issued_1", d, 64'd1);

        // Backpressure: queue full for 10 cycles with a SRC write pending
        ctrl_if.cmdq_status.full = 1'b1;
        base = newcmd_cnt;
        mmio_wr(A_LEN, 64'h80, 8'hFF);
        mmio_address = A_SRC; mmio_writedata = 64'h3000; mmio_byteenable = 8'hFF;
        mmio_write = 1'b1;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (mmio_waitrequest !== 1'b1) ok = 0;
            @(negedge clk);
        end
        check("bp_hold", 64'(ok), 64'd1);
        check("bp_no_issue", 64'(newcmd_cnt - base), 64'd0);
        ctrl_if.cmdq_status.full = 1'b0;
        n = 0;
        while (mmio_waitrequest && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_release_cycles", 64'(n), 64'd3);
        check("bp_one_issue", 64'(newcmd_cnt - base), 64'd1);
        @(posedge clk);
        @(negedge clk);
        mmio_write = 1'b0;
        check("bp_cmd_src", ctrl_if.cmd.src_addr, 64'h1000);
        check("bp_cmd_len", 64'(ctrl_if.cmd.xfer_length), 64'h80);
        mmio_rd(A_SRC, d);    check("bp_src_written", d, 64'h3000);
        mmio_rd(A_ISSUED, d); check("issued_2", d, 64'd2);

        // Soft reset while waiting for queue space
        ctrl_if.cmdq_status.full = 1'b1;
        base = newcmd_cnt;
        mmio_wr(A_LEN, 64'h100, 8'hFF);
        @(negedge clk);
        mmio_wr(A_CTRL, 64'h1, 8'hFF);
        ctrl_if.cmdq_status.full = 1'b0;
        count_sclr(hi);
        check("srst_sclr_cycles", 64'(hi), 64'd16);
        check("srst_no_issue", 64'(newcmd_cnt - base), 64'd0);
        mmio_rd(A_STATUS, d); check("srst_status_idle", d, 64'd0);
        mmio_rd(A_SRC, d);    check("srst_src_kept", d, 64'h3000);
        mmio_rd(A_ISSUED, d); check("srst_issued_clr", d, 64'd0);
        check("srst_cmd_held", 64'(ctrl_if.cmd.xfer_length), 64'h100);

        // IRQ clear, then both CONTROL bits together
        mmio_wr(A_CTRL, 64'h2, 8'hFF);
        check("irq_pulse", 64'(ctrl_if.clear_irq), 64'd1);
        check("irq_no_sclr", 64'(ctrl_if.sclr), 64'd0);
        @(negedge clk);
        check("irq_pulse_end", 64'(ctrl_if.clear_irq), 64'd0);
        mmio_wr(A_CTRL, 64'h3, 8'hFF);
        check("both_irq", 64'(ctrl_if.clear_irq), 64'd1);
        count_sclr(hi);
        check("both_sclr_cycles", 64'(hi), 64'd16);

        // Byte-enable merge on MAGIC_ADDR
        mmio_wr(A_MAGIC, 64'h1122_3344_5566_7788, 8'hFF);
        check("magic_mirror", ctrl_if.host_mem_magicnumber_addr, 64'h1122_3344_5566_7788);
        mmio_wr(A_MAGIC, 64'h0000_0000_FFFF_FFFF, 8'h0F);
        mmio_rd(A_MAGIC, d);
        check("magic_be", d, 64'h1122_3344_FFFF_FFFF);
        check("magic_mirror_be", ctrl_if.host_mem_magicnumber_addr, 64'h1122_3344_FFFF_FFFF);

        // Soft reset landing in the ISSUE cycle
        base = newcmd_cnt;
        mmio_wr(A_LEN, 64'h200, 8'hFF);
        @(negedge clk);
        mmio_address = A_CTRL; mmio_writedata = 64'h1; mmio_byteenable = 8'hFF;
        mmio_write = 1'b1;
        #1;
        check("issue_srst_suppress", 64'(ctrl_if.new_cmd), 64'd0);
        @(posedge clk);
        @(negedge clk);
        mmio_write = 1'b0;
        check("issue_srst_count", 64'(newcmd_cnt - base), 64'd0);
        mmio_rd(A_ISSUED, d); check("issue_srst_issued", d, 64'd0);
        mmio_rd(A_STATUS, d); check("issue_srst_idle", d, 64'd0);

        // Debug counters, write-only CONTROL and unmapped space
        ctrl_if.dst_write_counter = 64'h55;
        ctrl_if.src_readdatavalid_counter = 64'hAA;
        @(negedge clk);
        mmio_rd(A_DBG_DW, d);
`ifdef DMA_DISPATCHER_DEBUG_COUNTERS_EN
        check("dbg_dst_write", d, 64'h55);
`else
        check("dbg_dst_write", d, 64'h0);
`endif
        mmio_rd(A_CTRL, d);   check("ctrl_reads_zero", d, 64'd0);
        mmio_wr(A_UNMAP1, 64'hDEAD, 8'hFF);
        mmio_rd(A_UNMAP1, d); check("unmapped_78", d, 64'd0);
        mmio_rd(A_UNMAP0, d); check("unmapped_70", d, 64'd0);
        mmio_rd(A_SRC, d);    check("unmapped_no_side", d, 64'h3000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
